// File: rtl/fir_window_integrator.sv
// Window integrator: sums lane samples over [trigger-pre_len, trigger+post_len]; result valid pre+post+2 clocks after the trigger edge.
// Result is held with q_valid until q_ready; trigger edges seen while busy or disarmed are counted in drop_cnt.
module fir_window_integrator #(
    parameter int NLANES = 4,
    parameter int SW     = 31,
    parameter int PRE_W  = 4,
    parameter int POST_W = 6,
    parameter int TS_W   = 32,
    localparam int LW    = (NLANES > 1) ? $clog2(NLANES) : 1,
    localparam int ACC_W = SW + $clog2(NLANES * (2**PRE_W + 2**POST_W))
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     enable,
    input  logic [PRE_W-1:0]         pre_len,
    input  logic [POST_W-1:0]        post_len,
    input  logic [NLANES-1:0]        trig_in,
    input  logic [NLANES*SW-1:0]     in_data,
    input  logic [TS_W-1:0]          ltc,
    output logic signed [ACC_W-1:0]  q_out,
    output logic [TS_W+LW-1:0]       t_out,
    output logic                     q_valid,
    input  logic                     q_ready,
    output logic                     busy,
    input  logic                     drop_clr,
    output logic [15:0]              drop_cnt
);
    localparam int SUM_W = SW + $clog2(NLANES);
    localparam int DEPTH = 2**PRE_W - 1;
    localparam int CW    = ((PRE_W > POST_W) ? PRE_W : POST_W) + 1;

    typedef enum logic [1:0] {IDLE, INTEG, OUTPUT, REARM} state_t;

    state_t                  state_q, state_d;
    logic signed [SUM_W-1:0] lane_sum, s_q, tap, tap_q;
    logic signed [SUM_W-1:0] dl_q [DEPTH];
    logic signed [ACC_W-1:0] acc_q, acc_d, q_out_q, q_out_d, acc_sum;
    logic [TS_W+LW-1:0]      t_out_q, t_out_d;
    logic [POST_W-1:0]       post_q, post_d;
    logic [PRE_W-1:0]        pre_len_r_q;
    logic [CW-1:0]           cnt_q, cnt_d, n_last;
    logic [LW-1:0]           lane_enc;
    logic [15:0]             drop_q;
    logic                    q_valid_q, q_valid_d, any_trig, any_trig_q, trig_edge, drop_ev;

    assign any_trig  = |trig_in;
    assign trig_edge = any_trig && !any_trig_q;
    assign acc_sum   = acc_q + ACC_W'(tap_q);
    assign n_last    = CW'(pre_len_r_q) + CW'(post_q) + CW'(1);

    always_comb begin
        lane_sum = '0;
        for (int i = 0; i < NLANES; i++)
            lane_sum = lane_sum + SUM_W'($signed(in_data[i*SW +: SW]));
    end

    always_comb begin
        lane_enc = '0;
        for (int i = NLANES-1; i >= 0; i--)
            if (trig_in[i]) lane_enc = LW'(i);
    end

    always_comb begin
        if (pre_len_r_q == '0) tap = s_q;
        else                   tap = dl_q[pre_len_r_q - PRE_W'(1)];
    end

    // Delay line is wiped while disarmed so pre-trigger history from before enable reads as zero.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) dl_q[i] <= '0;
        end else if (!enable) begin
            for (int i = 0; i < DEPTH; i++) dl_q[i] <= '0;
        end else begin
            dl_q[0] <= s_q;
            for (int i = 1; i < DEPTH; i++) dl_q[i] <= dl_q[i-1];
        end
    end

    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        q_out_d   = q_out_q;
        q_valid_d = q_valid_q;
        t_out_d   = t_out_q;
        post_d    = post_q;
        drop_ev   = 1'b0;
        case (state_q)
            IDLE: begin
                if (trig_edge) begin
                    if (enable) begin
                        state_d = INTEG;
                        post_d  = post_len;
                        t_out_d = {ltc, lane_enc};
                        acc_d   = '0;
                        cnt_d   = '0;
                    end else begin
                        drop_ev = 1'b1;
                    end
                end
            end
            INTEG: begin
                drop_ev = trig_edge;
                if (!enable) begin
                    state_d = IDLE;
                end else begin
                    // First clock after the trigger only fills the tap register.
                    cnt_d = cnt_q + CW'(1);
                    if (cnt_q != '0) acc_d = acc_sum;
                    if (cnt_q == n_last) begin
                        q_out_d   = acc_sum;
                        q_valid_d = 1'b1;
                        state_d   = OUTPUT;
                    end
                end
            end
            OUTPUT: begin
                drop_ev = trig_edge;
                if (q_ready) begin
                    q_valid_d = 1'b0;
                    state_d   = any_trig ? REARM : IDLE;
                end
            end
            REARM: begin
                drop_ev = trig_edge;
                if (!any_trig) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            cnt_q       <= '0;
            q_out_q     <= '0;
            q_valid_q   <= 1'b0;
            t_out_q     <= '0;
            post_q      <= '0;
            s_q         <= '0;
            tap_q       <= '0;
            pre_len_r_q <= '0;
            any_trig_q  <= 1'b0;
            drop_q      <= '0;
        end else begin
            state_q    <= state_d;
            acc_q      <= acc_d;
            cnt_q      <= cnt_d;
            q_out_q    <= q_out_d;
            q_valid_q  <= q_valid_d;
            t_out_q    <= t_out_d;
            post_q     <= post_d;
            s_q        <= lane_sum;
            tap_q      <= tap;
            any_trig_q <= any_trig;
            if (!enable) pre_len_r_q <= pre_len;
            if (drop_clr)                     drop_q <= '0;
            else if (drop_ev && drop_q != '1) drop_q <= drop_q + 16'd1;
        end
    end

    assign q_out    = q_out_q;
    assign t_out    = t_out_q;
    assign q_valid  = q_valid_q;
    assign busy     = (state_q != IDLE);
    assign drop_cnt = drop_q;
endmodule
